// File: rtl/aim_stream_matcher.sv
// Associative index matcher: N_LANE keys searched against a streamed index.
// Reports per-lane found, lowest absolute match position and multi-match.
module aim_stream_matcher #(
  parameter int N_LANE    = 32,
  parameter int CHUNK     = 32,
  parameter int KEY_W     = 16,
  parameter int MAX_CHUNK = 8,
  localparam int POS_W    = $clog2(CHUNK*MAX_CHUNK),
  localparam int CNT_W    = $clog2(MAX_CHUNK+1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [CNT_W-1:0]          i_n_chunk,
  input  logic [N_LANE*KEY_W-1:0]   i_key,
  input  logic                      i_chunk_valid,
  output logic                      o_chunk_ready,
  input  logic [CHUNK*KEY_W-1:0]    i_chunk,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [N_LANE-1:0]         o_found,
  output logic [N_LANE-1:0]         o_multi,
  output logic [N_LANE*POS_W-1:0]   o_pos
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [N_LANE*KEY_W-1:0]   r_key;
  logic [CNT_W-1:0]          r_n;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_done;
  logic [N_LANE-1:0]         r_found;
  logic [N_LANE-1:0]         r_multi;
  logic [N_LANE*POS_W-1:0]   r_pos;

  logic [N_LANE-1:0]         w_hit_any;
  logic [N_LANE-1:0]         w_hit_two;
  logic [N_LANE*POS_W-1:0]   w_off;
  logic [POS_W-1:0]          w_base;
  logic [CNT_W-1:0]          w_n;
  logic                      w_last;

  assign o_chunk_ready = (r_state == S_RUN);
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_found       = r_found;
  assign o_multi       = r_multi;
  assign o_pos         = r_pos;

  assign w_n = (i_n_chunk > CNT_W'(MAX_CHUNK)) ?
               CNT_W'(MAX_CHUNK) : i_n_chunk;
  assign w_base = POS_W'(32'(r_cnt) * CHUNK);
  assign w_last = (r_cnt == r_n - CNT_W'(1));

  // Per-lane compare of the current chunk: any hit, two or more hits,
  // and the lowest hitting entry (scan high to low, last write wins).
  always_comb begin
    w_hit_any = '0;
    w_hit_two = '0;
    w_off     = '0;
    for (int l = 0; l < N_LANE; l++) begin
      for (int e = CHUNK-1; e >= 0; e--) begin
        if (r_key[l*KEY_W +: KEY_W] == i_chunk[e*KEY_W +: KEY_W]) begin
          if (w_hit_any[l]) w_hit_two[l] = 1'b1;
          w_hit_any[l] = 1'b1;
          w_off[l*POS_W +: POS_W] = POS_W'(e);
        end
      end
    end
  end

  // Search FSM with registered results and done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_found <= '0;
      r_multi <= '0;
      r_pos   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!i_abort && i_start) begin
            r_key   <= i_key;
            r_n     <= w_n;
            r_cnt   <= '0;
            r_found <= '0;
            r_multi <= '0;
            r_pos   <= '0;
            if (w_n == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_state <= S_IDLE;
          end else if (i_chunk_valid) begin
            for (int l = 0; l < N_LANE; l++) begin
              if (w_hit_any[l]) begin
                if (!r_found[l]) begin
                  r_found[l] <= 1'b1;
                  r_pos[l*POS_W +: POS_W] <=
                    w_base + w_off[l*POS_W +: POS_W];
                end else begin
                  r_multi[l] <= 1'b1;
                end
                if (w_hit_two[l]) r_multi[l] <= 1'b1;
              end
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aim_stream_matcher.sv
// Scoreboard bench for aim_stream_matcher: expected results are
// computed from the stimulus tables and queued at search start.
module tb_aim_stream_matcher;

  localparam int NL  = 32;
  localparam int CH  = 32;
  localparam int KW  = 16;
  localparam int MC  = 8;
  localparam int PW  = 8;
  localparam int CW  = 4;

  typedef struct packed {
    logic [NL-1:0]    f;
    logic [NL-1:0]    m;
    logic [NL*PW-1:0] p;
  } exp_t;

  logic              i_clk = 0;
  logic              i_rst_n = 0;
  logic              i_start = 0;
  logic              i_abort = 0;
  logic [CW-1:0]     i_n_chunk = '0;
  logic [NL*KW-1:0]  i_key = '0;
  logic              i_chunk_valid = 0;
  logic              o_chunk_ready;
  logic [CH*KW-1:0]  i_chunk = '0;
  logic              o_busy;
  logic              o_done;
  logic [NL-1:0]     o_found;
  logic [NL-1:0]     o_multi;
  logic [NL*PW-1:0]  o_pos;

  int n_vec = 0;
  int n_err = 0;

  logic [KW-1:0] keys [NL];
  logic [KW-1:0] chunks [MC][CH];
  exp_t q[$];

  aim_stream_matcher dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_abort(i_abort), .i_n_chunk(i_n_chunk), .i_key(i_key),
    .i_chunk_valid(i_chunk_valid), .o_chunk_ready(o_chunk_ready),
    .i_chunk(i_chunk), .o_busy(o_busy), .o_done(o_done),
    .o_found(o_found), .o_multi(o_multi), .o_pos(o_pos)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int nu);
    exp_t r;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      int cnt;
      cnt = 0;
      for (int c = 0; c < nu; c++)
        for (int e = 0; e < CH; e++)
          if (chunks[c][e] == keys[l]) begin
            if (cnt == 0) r.p[l*PW +: PW] = 8'(c*CH + e);
            cnt++;
          end
      r.f[l] = (cnt > 0);
      r.m[l] = (cnt > 1);
    end
    return r;
  endfunction

  task automatic init_data();
    for (int l = 0; l < NL; l++) keys[l] = 16'h0100 + 16'(l);
    for (int c = 0; c < MC; c++)
      for (int e = 0; e < CH; e++)
        chunks[c][e] = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
    for (int l = 0; l < NL; l++) i_key[l*KW +: KW] = keys[l];
  endtask

  task automatic load_keys();
    for (int l = 0; l < NL; l++) i_key[l*KW +: KW] = keys[l];
  endtask

  task automatic pulse_start(input int n);
    i_n_chunk = CW'(n);
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
  endtask

  task automatic feed(input int c, input int gap);
    repeat (gap) @(negedge i_clk);
    for (int e = 0; e < CH; e++) i_chunk[e*KW +: KW] = chunks[c][e];
    i_chunk_valid = 1;
    n_vec++;
    if (o_chunk_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready chunk%0d: got %b want 1", c, o_chunk_ready);
    end
    @(negedge i_clk);
    i_chunk_valid = 0;
  endtask

  task automatic check_results(input string nm);
    exp_t x;
    if (q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    x = q.pop_front();
    n_vec++;
    if (o_found !== x.f) begin
      n_err++;
      $display("FAIL %s found: got %h want %h", nm, o_found, x.f);
    end
    n_vec++;
    if (o_multi !== x.m) begin
      n_err++;
      $display("FAIL %s multi: got %h want %h", nm, o_multi, x.m);
    end
    n_vec++;
    if (o_pos !== x.p) begin
      n_err++;
      $display("FAIL %s pos: got %h want %h", nm, o_pos, x.p);
    end
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (o_done !== 1'b1 && k < 40) begin
      @(negedge i_clk);
      k++;
    end
    n_vec++;
    if (k != 0) begin
      n_err++;
      $display("FAIL %s done_latency: got %0d extra cycles want 0", nm, k);
    end
    check_results(nm);
    @(negedge i_clk);
    n_vec++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_width: got done=%b busy=%b want 0 0",
               nm, o_done, o_busy);
    end
  endtask

  task automatic run(input string nm, input int n, input int gap);
    int nu;
    nu = (n > MC) ? MC : n;
    load_keys();
    q.push_back(model(nu));
    pulse_start(n);
    for (int c = 0; c < nu; c++) begin
      feed(c, gap);
      if (c < nu - 1) begin
        n_vec++;
        if (o_done !== 1'b0) begin
          n_err++;
          $display("FAIL %s early_done c%0d: got 1 want 0", nm, c);
        end
      end
    end
    wait_done(nm);
  endtask

  task automatic test_reset();
    n_vec++;
    if ({o_busy, o_done, o_chunk_ready} !== 3'b000 ||
        o_found !== '0 || o_multi !== '0 || o_pos !== '0) begin
      n_err++;
      $display("FAIL reset: got busy=%b done=%b rdy=%b f=%h m=%h want 0",
               o_busy, o_done, o_chunk_ready, o_found, o_multi);
    end
  endtask

  task automatic test_single();
    init_data();
    keys[0] = 16'h0005;
    chunks[0][7] = 16'h0005;
    run("single", 1, 0);
    n_vec++;
    if (o_found[0] !== 1'b1 || o_pos[7:0] !== 8'd7 || o_multi[0] !== 1'b0) begin
      n_err++;
      $display("FAIL single_lane0: got f=%b p=%0d m=%b want 1 7 0",
               o_found[0], o_pos[7:0], o_multi[0]);
    end
  endtask

  task automatic test_gaps();
    init_data();
    chunks[3][31] = keys[3];
    chunks[5][0]  = keys[3];
    chunks[6][12] = keys[20];
    run("gaps", 8, 2);
    n_vec++;
    if (o_pos[3*PW +: PW] !== 8'd127 || o_multi[3] !== 1'b1) begin
      n_err++;
      $display("FAIL gaps_lane3: got p=%0d m=%b want 127 1",
               o_pos[3*PW +: PW], o_multi[3]);
    end
  endtask

  task automatic test_multi_in_chunk();
    init_data();
    chunks[0][4] = keys[1];
    chunks[0][9] = keys[1];
    run("multi_chunk", 1, 0);
    n_vec++;
    if (o_pos[1*PW +: PW] !== 8'd4 || o_multi[1] !== 1'b1) begin
      n_err++;
      $display("FAIL multi_chunk_lane1: got p=%0d m=%b want 4 1",
               o_pos[1*PW +: PW], o_multi[1]);
    end
  endtask

  task automatic test_zero_chunk();
    init_data();
    load_keys();
    q.push_back(model(0));
    i_n_chunk = '0;
    i_start = 1;
    @(negedge i_clk);
    i_start = 0;
    n_vec++;
    if (o_chunk_ready !== 1'b0) begin
      n_err++;
      $display("FAIL zero_ready: got %b want 0", o_chunk_ready);
    end
    wait_done("zero_chunk");
  endtask

  task automatic test_start_ignored();
    init_data();
    chunks[1][2] = keys[9];
    load_keys();
    q.push_back(model(2));
    pulse_start(2);
    feed(0, 0);
    i_key = ~i_key;
    pulse_start(1);
    load_keys();
    n_vec++;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_busy: got done=%b busy=%b want 0 1",
               o_done, o_busy);
    end
    feed(1, 0);
    wait_done("start_ignored");
  endtask

  task automatic test_clamp();
    init_data();
    chunks[7][31] = keys[31];
    run("clamp", 15, 0);
  endtask

  task automatic test_abort();
    int seen;
    init_data();
    chunks[1][5] = keys[2];
    chunks[2][6] = keys[4];
    load_keys();
    q.push_back(model(2));
    pulse_start(4);
    feed(0, 0);
    feed(1, 0);
    for (int e = 0; e < CH; e++) i_chunk[e*KW +: KW] = chunks[2][e];
    i_chunk_valid = 1;
    i_abort = 1;
    @(negedge i_clk);
    i_chunk_valid = 0;
    i_abort = 0;
    n_vec++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b done=%b want 0 0",
               o_busy, o_done);
    end
    check_results("abort_partial");
    seen = 0;
    repeat (4) begin
      @(negedge i_clk);
      if (o_done === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL abort_nodone: got %0d pulses want 0", seen);
    end
    init_data();
    chunks[0][30] = keys[6];
    run("after_abort", 1, 0);
  endtask

  task automatic test_abort_start_idle();
    i_start = 1;
    i_abort = 1;
    i_n_chunk = 4'd2;
    @(negedge i_clk);
    i_start = 0;
    i_abort = 0;
    n_vec++;
    if (o_busy !== 1'b0 || o_chunk_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_start: got busy=%b rdy=%b want 0 0",
               o_busy, o_chunk_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    init_data();
    chunks[0][0] = keys[0];
    load_keys();
    pulse_start(4);
    feed(0, 0);
    #2 i_rst_n = 0;
    #1;
    n_vec++;
    if ({o_busy, o_done, o_chunk_ready} !== 3'b000 ||
        o_found !== '0 || o_multi !== '0 || o_pos !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got busy=%b done=%b rdy=%b f=%h want 0",
               o_busy, o_done, o_chunk_ready, o_found);
    end
    @(negedge i_clk);
    i_rst_n = 1;
    @(negedge i_clk);
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, 8);
      init_data();
      for (int h = 0; h < 12; h++)
        chunks[$urandom_range(0, n-1)][$urandom_range(0, CH-1)] =
          keys[$urandom_range(0, NL-1)];
      run($sformatf("rand%0d", t), n, $urandom_range(0, 1));
    end
  endtask

  initial begin
    i_rst_n = 0;
    repeat (3) @(negedge i_clk);
    test_reset();
    i_rst_n = 1;
    @(negedge i_clk);
    test_single();
    test_gaps();
    test_multi_in_chunk();
    test_zero_chunk();
    test_start_ignored();
    test_clamp();
    test_abort();
    test_abort_start_idle();
    test_reset_mid_run();
    test_random();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d entries want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
